// File: rtl/pwm_capture.sv
// PWM input capture: measures period and high time of an external PWM line
// and reports integer duty in percent through a fixed-latency restoring divider.
module pwm_capture #(
  parameter int CNT_W          = 24,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             pwm_in,
  output logic [7:0]       duty_cycle,
  output logic             duty_valid,
  output logic [CNT_W-1:0] period,
  output logic             signal_lost,
  output logic             overrun
);

  localparam int               DVD_W    = CNT_W + 7;
  localparam logic [CNT_W-1:0] TIMEOUT  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [3:0]       PH_IDLE  = 4'd0;
  localparam logic [3:0]       PH_LOAD  = 4'd1;
  localparam logic [3:0]       PH_FIRST = 4'd2;
  localparam logic [3:0]       PH_LAST  = 4'd8;
  localparam logic [3:0]       PH_OUT   = 4'd9;

  typedef enum logic {IDLE, MEASURE} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic              inc);
    if (inc && (v != {CNT_W{1'b1}}))
      return v + CNT_W'(1);
    return v;
  endfunction

  // One restoring step: returns {quotient_bit, next_remainder}.
  function automatic logic [CNT_W:0] div_step(input logic [CNT_W-1:0] rem,
                                              input logic              nb,
                                              input logic [CNT_W-1:0] d);
    logic signed [CNT_W+1:0] diff;
    diff = $signed({1'b0, rem, nb}) - $signed({2'b00, d});
    if (diff[CNT_W+1])
      return {1'b0, rem[CNT_W-2:0], nb};
    return {1'b1, diff[CNT_W-1:0]};
  endfunction

  logic             s1, s2, s3, rise;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] period_cnt, high_cnt, period_cnt_nxt, high_cnt_nxt;
  logic [3:0]       phase;
  logic             close, accept, drop, div_done, div_free, timeout_hit;
  logic [CNT_W-1:0] meas_h_p0, meas_p_p0;
  logic [DVD_W-1:0] prod_p0;
  logic [CNT_W-1:0] rem_p1;
  logic [6:0]       low_p1, quo_p1;
  logic [CNT_W:0]   step_p1;

  // Input synchronizer and edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  assign close    = en && (state == MEASURE) && rise;
  assign div_done = (phase == PH_OUT);
  assign div_free = (phase == PH_IDLE) || div_done;
  assign accept   = close && div_free;
  assign drop     = close && !div_free;

  // Held off while a strobe is pending or active so duty_valid never repeats.
  assign timeout_hit = en && (state == MEASURE) && !rise &&
                       (period_cnt >= TIMEOUT) && !div_done && !duty_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      period_cnt <= '0;
      high_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      period_cnt <= period_cnt_nxt;
      high_cnt   <= high_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    period_cnt_nxt = period_cnt;
    high_cnt_nxt   = high_cnt;
    if (!en) begin
      state_nxt      = IDLE;
      period_cnt_nxt = '0;
      high_cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          period_cnt_nxt = '0;
          high_cnt_nxt   = '0;
          if (rise) begin
            state_nxt      = MEASURE;
            period_cnt_nxt = CNT_W'(1);
            high_cnt_nxt   = CNT_W'(1);
          end
        end
        MEASURE: begin
          if (rise) begin
            period_cnt_nxt = CNT_W'(1);
            high_cnt_nxt   = CNT_W'(1);
          end else if (timeout_hit) begin
            state_nxt      = IDLE;
            period_cnt_nxt = '0;
            high_cnt_nxt   = '0;
          end else begin
            period_cnt_nxt = sat_inc(period_cnt, 1'b1);
            high_cnt_nxt   = sat_inc(high_cnt, s2);
          end
        end
        default: begin
          state_nxt      = IDLE;
          period_cnt_nxt = '0;
          high_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Divider sequencing: capture, load, 7 iterations, output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= PH_IDLE;
    end else if (!en) begin
      phase <= PH_IDLE;
    end else if (accept) begin
      phase <= PH_LOAD;
    end else if (div_done) begin
      phase <= PH_IDLE;
    end else if (phase != PH_IDLE) begin
      phase <= phase + 4'd1;
    end
  end

  // Q <= 100 < 128, so the top CNT_W bits of H*100 are already below P and
  // seed the remainder; only the low 7 dividend bits need iterating.
  assign prod_p0 = DVD_W'(meas_h_p0) * DVD_W'(100);
  assign step_p1 = div_step(rem_p1, low_p1[6], meas_p_p0);

  always_ff @(posedge clk) begin
    if (accept) begin
      meas_h_p0 <= high_cnt;
      meas_p_p0 <= period_cnt;
    end
    if (phase == PH_LOAD) begin
      rem_p1 <= prod_p0[DVD_W-1:7];
      low_p1 <= prod_p0[6:0];
      quo_p1 <= '0;
    end else if ((phase >= PH_FIRST) && (phase <= PH_LAST)) begin
      rem_p1 <= step_p1[CNT_W-1:0];
      low_p1 <= {low_p1[5:0], 1'b0};
      quo_p1 <= {quo_p1[5:0], step_p1[CNT_W]};
    end
  end

  // Output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_cycle  <= '0;
      duty_valid  <= 1'b0;
      period      <= '0;
      signal_lost <= 1'b0;
      overrun     <= 1'b0;
    end else if (!en) begin
      duty_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      overrun    <= drop;
      if (div_done) begin
        duty_cycle  <= {1'b0, quo_p1};
        period      <= meas_p_p0;
        duty_valid  <= 1'b1;
        signal_lost <= 1'b0;
      end else if (timeout_hit) begin
        duty_cycle  <= s2 ? 8'd100 : 8'd0;
        period      <= '0;
        duty_valid  <= 1'b1;
        signal_lost <= 1'b1;
      end
    end
  end

endmodule
